// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, latched command and memory timing.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        we;
    } mem_cmd_t;

    localparam int unsigned MEM_READ_LATENCY = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester channels plus the single SRAM port, bundled for the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ-1:0][3:0]  req_wmask;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [31:0]              resp_rdata;
    logic                     resp_err;
    logic [31:0]              mem_address;
    logic [31:0]              mem_write_data;
    logic                     mem_write_enable;
    logic [3:0]               mem_write_mask;
    logic                     mem_read_enable;
    logic [31:0]              mem_read_data;
    logic                     mem_read_valid;

    // Arbiter side.
    modport master (
        input  req_valid, req_addr, req_wdata, req_we, req_wmask,
        input  mem_read_data, mem_read_valid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_write_enable, mem_write_mask, mem_read_enable
    );

    // Requesters plus memory side.
    modport slave (
        output req_valid, req_addr, req_wdata, req_we, req_wmask,
        output mem_read_data, mem_read_valid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_write_enable, mem_write_mask, mem_read_enable
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr_i) + i) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among NUM_REQ requesters, one transaction at a time,
// with a watchdog that turns a never-answered read into an error response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.master bus
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    mem_cmd_t           cmd_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               mem_we_q;
    logic               mem_re_q;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               gvalid;
    logic               accept;
    logic               rd_done;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .valid_o (gvalid)
    );

    assign accept        = (state_q == IDLE) && gvalid;
    assign bus.req_ready = (state_q == IDLE) ? grant : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        rd_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gvalid) begin
                    state_d  = bus.req_we[gidx] ? WR : RD_WAIT;
                    rr_ptr_d = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end
            end
            WR: state_d = RESP;
            RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Valid is ignored until the memory has had its latency to answer this request.
                if ((cnt_q >= CW'(MEM_READ_LATENCY)) && bus.mem_read_valid) begin
                    rd_done = 1'b1;
                    state_d = RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            cmd_q        <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= (state_d == WR);
            mem_re_q     <= (state_d == RD_WAIT);
            resp_valid_q <= '0;
            if (accept) begin
                owner_q <= gidx;
                cmd_q   <= '{addr:  bus.req_addr[gidx],
                             wdata: bus.req_wdata[gidx],
                             wmask: bus.req_wmask[gidx],
                             we:    bus.req_we[gidx]};
            end
            if (state_d == RESP) begin
                resp_valid_q[owner_q] <= 1'b1;
            end
            if (state_q == WR) begin
                resp_err_q <= 1'b0;
            end
            if ((state_q == RD_WAIT) && (state_d == RESP)) begin
                resp_rdata_q <= rd_done ? bus.mem_read_data : '0;
                resp_err_q   <= !rd_done;
            end
        end
    end

    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.resp_err         = resp_err_q;
    assign bus.mem_address      = cmd_q.addr;
    assign bus.mem_write_data   = cmd_q.wdata;
    assign bus.mem_write_mask   = cmd_q.wmask;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_read_enable  = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed 1-cycle-latency memory model.
module tb_dmem_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          mem_stall = 1'b0;
    int unsigned total_cnt = 0;
    int unsigned pass_cnt = 0;
    logic [7:0]  mem_bytes [256];

    dmem_arbiter_if #(.NUM_REQ(NR)) ifc();

    dmem_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [7:0]  ba;
        logic [31:0] rd;
        ba = 8'h00;
        rd = 32'h0;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_bytes[i] <= 8'h00;
            ifc.mem_read_valid <= 1'b0;
            ifc.mem_read_data  <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ba = ifc.mem_address[7:0] + 8'(i);
                rd[8*i +: 8] = mem_bytes[ba];
                if (ifc.mem_write_enable && ifc.mem_write_mask[i])
                    mem_bytes[ba] <= ifc.mem_write_data[8*i +: 8];
            end
            ifc.mem_read_valid <= ifc.mem_read_enable && !mem_stall;
            ifc.mem_read_data  <= rd;
        end
    end

    // Drives one request, waits (bounded) for its grant and response; lat counts cycles after the acceptance edge.
    task automatic run_txn(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, output bit granted, output int lat,
                           output logic [31:0] rdata, output logic err);
        granted = 1'b0;
        lat     = -1;
        rdata   = 32'hx;
        err     = 1'bx;
        @(negedge clk);
        ifc.req_we[id]    = we;
        ifc.req_addr[id]  = addr;
        ifc.req_wdata[id] = wdata;
        ifc.req_wmask[id] = wmask;
        ifc.req_valid[id] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ifc.req_ready[id] === 1'b1) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ifc.req_valid[id] = 1'b0;
        if (granted) begin
            for (int c = 1; c <= 40; c++) begin
                #1;
                if (ifc.resp_valid[id] === 1'b1) begin
                    lat   = c;
                    rdata = ifc.resp_rdata;
                    err   = ifc.resp_err;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (ifc.req_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", ifc.req_ready); else pass_cnt++;
        total_cnt++; if (ifc.resp_valid !== 2'b00) $display("FAIL reset_resp_valid got=%b exp=00", ifc.resp_valid); else pass_cnt++;
        total_cnt++; if (ifc.resp_err !== 1'b0) $display("FAIL reset_resp_err got=%b exp=0", ifc.resp_err); else pass_cnt++;
        total_cnt++; if (ifc.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata got=%h exp=0", ifc.resp_rdata); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_enable !== 1'b0) $display("FAIL reset_we got=%b exp=0", ifc.mem_write_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_read_enable !== 1'b0) $display("FAIL reset_re got=%b exp=0", ifc.mem_read_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_address !== 32'h0) $display("FAIL reset_addr got=%h exp=0", ifc.mem_address); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_data !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", ifc.mem_write_data); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_mask !== 4'h0) $display("FAIL reset_wmask got=%h exp=0", ifc.mem_write_mask); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        int             pending;
        int             gcount;
        int             rcount;
        logic [NR-1:0]  exp_oh;
        pending = -1;
        gcount  = 0;
        rcount  = 0;
        @(negedge clk);
        ifc.req_we       = 2'b11;
        ifc.req_addr[0]  = 32'h40;
        ifc.req_addr[1]  = 32'h80;
        ifc.req_wdata[0] = 32'hA0A0A0A0;
        ifc.req_wdata[1] = 32'hB1B1B1B1;
        ifc.req_wmask[0] = 4'hF;
        ifc.req_wmask[1] = 4'hF;
        ifc.req_valid    = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ifc.resp_valid !== 2'b00) begin
                exp_oh = (pending == 1) ? 2'b10 : 2'b01;
                total_cnt++;
                if (pending < 0 || ifc.resp_valid !== exp_oh)
                    $display("FAIL contention_resp cycle=%0d got=%b exp=%b pending=%0d", c, ifc.resp_valid, exp_oh, pending);
                else pass_cnt++;
                pending = -1;
                rcount++;
            end
            if (ifc.req_ready !== 2'b00) begin
                exp_oh = (gcount % 2 == 0) ? 2'b01 : 2'b10;
                total_cnt++;
                if (ifc.req_ready !== exp_oh || pending >= 0)
                    $display("FAIL contention_grant cycle=%0d got=%b exp=%b pending=%0d", c, ifc.req_ready, exp_oh, pending);
                else pass_cnt++;
                pending = (ifc.req_ready == 2'b10) ? 1 : 0;
                gcount++;
            end
            @(negedge clk);
        end
        ifc.req_valid = 2'b00;
        total_cnt++; if (gcount !== 4) $display("FAIL contention_grants got=%0d exp=4", gcount); else pass_cnt++;
        total_cnt++; if (rcount !== 4) $display("FAIL contention_resps got=%0d exp=4", rcount); else pass_cnt++;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        ifc.req_we[0]    = 1'b1;
        ifc.req_addr[0]  = 32'h10;
        ifc.req_wdata[0] = 32'hDEADBEEF;
        ifc.req_wmask[0] = 4'hF;
        ifc.req_valid    = 2'b01;
        #1;
        total_cnt++; if (ifc.req_ready !== 2'b01) $display("FAIL wr_ready got=%b exp=01", ifc.req_ready); else pass_cnt++;
        @(negedge clk);
        ifc.req_valid = 2'b00;
        #1;
        total_cnt++; if (ifc.mem_write_enable !== 1'b1) $display("FAIL wr_we_t1 got=%b exp=1", ifc.mem_write_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_read_enable !== 1'b0) $display("FAIL wr_re_t1 got=%b exp=0", ifc.mem_read_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_address !== 32'h10) $display("FAIL wr_addr got=%h exp=10", ifc.mem_address); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_data !== 32'hDEADBEEF) $display("FAIL wr_data got=%h exp=deadbeef", ifc.mem_write_data); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_mask !== 4'hF) $display("FAIL wr_mask got=%h exp=f", ifc.mem_write_mask); else pass_cnt++;
        total_cnt++; if (ifc.resp_valid !== 2'b00) $display("FAIL wr_resp_early got=%b exp=00", ifc.resp_valid); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ifc.resp_valid !== 2'b01) $display("FAIL wr_resp_t2 got=%b exp=01", ifc.resp_valid); else pass_cnt++;
        total_cnt++; if (ifc.resp_err !== 1'b0) $display("FAIL wr_err got=%b exp=0", ifc.resp_err); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_enable !== 1'b0) $display("FAIL wr_we_t2 got=%b exp=0", ifc.mem_write_enable); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ifc.resp_valid !== 2'b00) $display("FAIL wr_resp_t3 got=%b exp=00", ifc.resp_valid); else pass_cnt++;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ifc.req_we[1]   = 1'b0;
        ifc.req_addr[1] = 32'h10;
        ifc.req_valid   = 2'b10;
        #1;
        total_cnt++; if (ifc.req_ready !== 2'b10) $display("FAIL rd_ready got=%b exp=10", ifc.req_ready); else pass_cnt++;
        @(negedge clk);
        ifc.req_valid = 2'b00;
        #1;
        total_cnt++; if (ifc.mem_read_enable !== 1'b1) $display("FAIL rd_re_t1 got=%b exp=1", ifc.mem_read_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_write_enable !== 1'b0) $display("FAIL rd_we_t1 got=%b exp=0", ifc.mem_write_enable); else pass_cnt++;
        total_cnt++; if (ifc.mem_address !== 32'h10) $display("FAIL rd_addr got=%h exp=10", ifc.mem_address); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ifc.mem_read_enable !== 1'b1) $display("FAIL rd_re_t2 got=%b exp=1", ifc.mem_read_enable); else pass_cnt++;
        total_cnt++; if (ifc.resp_valid !== 2'b00) $display("FAIL rd_resp_early got=%b exp=00", ifc.resp_valid); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (ifc.resp_valid !== 2'b10) $display("FAIL rd_resp_t3 got=%b exp=10", ifc.resp_valid); else pass_cnt++;
        total_cnt++; if (ifc.resp_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", ifc.resp_rdata); else pass_cnt++;
        total_cnt++; if (ifc.resp_err !== 1'b0) $display("FAIL rd_err got=%b exp=0", ifc.resp_err); else pass_cnt++;
        total_cnt++; if (ifc.mem_read_enable !== 1'b0) $display("FAIL rd_re_t3 got=%b exp=0", ifc.mem_read_enable); else pass_cnt++;
    endtask

    task automatic test_partial_write();
        bit          g;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        run_txn(0, 1'b1, 32'h13, 32'h11223344, 4'h3, g, lat, rdata, err);
        total_cnt++; if (!g || lat != 2 || err !== 1'b0) $display("FAIL pw_write granted=%0d lat=%0d err=%b exp lat=2 err=0", g, lat, err); else pass_cnt++;
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, g, lat, rdata, err);
        total_cnt++; if (!g || lat != 3) $display("FAIL pw_rd10_lat granted=%0d lat=%0d exp=3", g, lat); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h44ADBEEF) $display("FAIL pw_rd10_data got=%h exp=44adbeef", rdata); else pass_cnt++;
        run_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, g, lat, rdata, err);
        total_cnt++; if (!g || lat != 3) $display("FAIL pw_rd14_lat granted=%0d lat=%0d exp=3", g, lat); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h00000033) $display("FAIL pw_rd14_data got=%h exp=00000033", rdata); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit          g;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        mem_stall = 1'b1;
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, g, lat, rdata, err);
        mem_stall = 1'b0;
        // TIMEOUT cycles of RD_WAIT after the acceptance edge, then the RESP cycle.
        total_cnt++; if (!g || lat != int'(TO) + 1) $display("FAIL to_lat granted=%0d lat=%0d exp=%0d", g, lat, TO + 1); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL to_err got=%b exp=1", err); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL to_rdata got=%h exp=0", rdata); else pass_cnt++;
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, g, lat, rdata, err);
        total_cnt++; if (!g || lat != 3 || err !== 1'b0 || rdata !== 32'h44ADBEEF)
            $display("FAIL to_recover granted=%0d lat=%0d err=%b data=%h exp lat=3 err=0 data=44adbeef", g, lat, err, rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        bit g;
        int seen;
        g    = 1'b0;
        seen = 0;
        @(negedge clk);
        ifc.req_we      = 2'b00;
        ifc.req_addr[1] = 32'h10;
        ifc.req_valid   = 2'b10;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ifc.req_ready[1] === 1'b1) begin
                g = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ifc.req_valid = 2'b00;
        #1;
        total_cnt++; if (!g || ifc.mem_read_enable !== 1'b1) $display("FAIL rst_mid_rdwait granted=%0d re=%b exp re=1", g, ifc.mem_read_enable); else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++; if (ifc.mem_read_enable !== 1'b0 || ifc.mem_write_enable !== 1'b0)
            $display("FAIL rst_mid_en re=%b we=%b exp 0 0", ifc.mem_read_enable, ifc.mem_write_enable);
        else pass_cnt++;
        total_cnt++; if (ifc.resp_valid !== 2'b00 || ifc.req_ready !== 2'b00)
            $display("FAIL rst_mid_hs resp_valid=%b ready=%b exp 00 00", ifc.resp_valid, ifc.req_ready);
        else pass_cnt++;
        total_cnt++; if (ifc.mem_address !== 32'h0) $display("FAIL rst_mid_addr got=%h exp=0", ifc.mem_address); else pass_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (ifc.resp_valid !== 2'b00) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL rst_mid_no_resp got=%0d responses exp=0", seen); else pass_cnt++;
        @(negedge clk);
        ifc.req_valid = 2'b11;
        #1;
        total_cnt++; if (ifc.req_ready !== 2'b01) $display("FAIL rst_mid_regrant got=%b exp=01", ifc.req_ready); else pass_cnt++;
        @(negedge clk);
        ifc.req_valid = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        ifc.req_valid = '0;
        ifc.req_we    = '0;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        ifc.req_wmask = '0;
        test_reset();
        test_contention();
        test_single_write();
        test_single_read();
        test_partial_write();
        test_timeout();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port (4-bank SRAM wrapper with 1-cycle read latency and a read_valid flag) between NUM_REQ requesters, e.g. the load/store unit and the debug loader.
- Per-requester valid/ready request channel and a pulsed response channel.
- Round-robin grant; one transaction in flight at a time.
- Holds address and enables stable until the memory signals completion; a watchdog produces an error response if it never does.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- TIMEOUT, 15, max cycles in RD_WAIT before an error response (4-bit counter minimum)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle
- req_addr  in  NUM_REQ x 32  byte address
- req_wdata  in  NUM_REQ x 32  store data
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_wmask  in  NUM_REQ x 4  byte-lane mask for writes
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
- resp_rdata  out  32  read data; shared bus, qualified by resp_valid
- resp_err  out  1  read timed out; qualified by resp_valid
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write_data
- mem_write_enable  out  1  to memory write_enable
- mem_write_mask  out  4  to memory write_mask
- mem_read_enable  out  1  to memory read_enable
- mem_read_data  in  32  from memory read_data
- mem_read_valid  in  1  from memory read_valid

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state = IDLE, rr_ptr = 0, timeout counter = 0
  - all req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0
  - mem_write_enable = 0, mem_read_enable = 0, mem_address = 0, mem_write_data = 0, mem_write_mask = 0
- Reset mid-transaction aborts it: no response is issued, and a write already driven may or may not have landed.
- Every output is registered except req_ready, which is a combinational function of state, req_valid and rr_ptr.
- States: IDLE, WR, RD_WAIT, RESP.
- IDLE:
  - Grant the first valid requester scanning from rr_ptr upward, modulo NUM_REQ.
  - req_ready[g] = 1 for that cycle only; all other ready bits are 0.
  - On acceptance, register addr/wdata/wmask/we and owner = g. Set rr_ptr = (g+1) mod NUM_REQ.
  - Next state is WR if we = 1, otherwise RD_WAIT.
- WR (exactly one cycle):
  - mem_write_enable = 1, mem_read_enable = 0; address, data and mask come from the registered command.
  - Next state: RESP with resp_err = 0.
- RD_WAIT:
  - mem_read_enable = 1 and mem_write_enable = 0; mem_address is held constant.
  - The timeout counter increments each cycle.
  - If mem_read_valid = 1: capture mem_read_data into resp_rdata, set resp_err = 0, and go to RESP.
  - Else if counter == TIMEOUT: set resp_rdata = 0, resp_err = 1, and go to RESP.
  - The first cycle in RD_WAIT never samples mem_read_valid. This avoids a stale valid left over from a previous same-address read.
  - Nominal read: mem_read_valid seen on the 2nd RD_WAIT cycle.
- RESP (one cycle):
  - resp_valid[owner] = 1; all mem enables = 0; timeout counter cleared.
  - Next state: IDLE.
- Latency from acceptance edge T:
  - write: mem_write_enable during T+1, resp_valid during T+2
  - read: mem_read_enable during T+1..T+2, resp_valid during T+3
- Throughput: at most one transaction per 3 cycles (write) or 4 cycles (read).
- mem_address, mem_write_data and mem_write_mask hold their last value in IDLE and RESP. Only the enables are forced to 0.
- Responses cannot be back-pressured. A requester must accept resp_valid in the cycle it is asserted.
- A requester may drop req_valid before it is granted; no grant is issued for it.
- Unaligned addresses are passed through unmodified; the memory handles bank rotation.

Decomposition:
- Package dmem_arb_pkg:
  - state enum state_t {IDLE, WR, RD_WAIT, RESP}
  - typedef mem_cmd_t {addr[31:0], wdata[31:0], wmask[3:0], we}
  - localparam MEM_READ_LATENCY = 1
- Sub-module rr_arbiter (inputs req vector and rr_ptr; outputs one-hot grant and its index). It is purely combinational and reused by other shared-resource blocks.
- FSM, command register and watchdog live in dmem_arbiter.

Test Plan:
- Single write: req0 valid, we=1, addr=0x10, wdata=0xDEADBEEF, wmask=0xF -> req_ready[0] at T; mem_write_enable=1 with addr 0x10 at T+1; resp_valid[0] at T+2, resp_err=0.
- Single read: read back 0x10 via req1 -> mem_read_enable at T+1..T+2; resp_valid[1] at T+3 with resp_rdata=0xDEADBEEF.
- Contention: both requesters valid continuously, rr_ptr=0 after reset -> grants alternate 0,1,0,1. Each requester's response arrives before the next grant.
- Partial/unaligned write: addr=0x13, wdata=0x11223344, wmask=0x3, then a read at 0x10 -> byte 3 = 0x44, byte 4 at 0x14 = 0x33, other bytes unchanged.
- Timeout: memory model holds mem_read_valid=0 -> after TIMEOUT (15) cycles in RD_WAIT, resp_valid with resp_err=1 and resp_rdata=0; arbiter returns to IDLE.
- Reset mid-read: rst_n=0 during RD_WAIT -> next cycle all enables, ready and resp_valid are 0 and state is IDLE; no response ever issued; the next request is granted to req0.
